pc_word_deserializer: RTL and testbench
=======================================

PC_WORD_DESERIALIZER -- requirements
Module: pc_word_deserializer

Interface
REQ-001 SHALL have parameter NPCin, default 32, meaning output word width in bits; NPCin SHALL be a multiple of Nbyte.
REQ-002 SHALL have parameter Nbyte, default 8, meaning input byte width in bits.
REQ-003 SHALL have parameter Ntimeout, default 1024, meaning the number of idle cycles after which a partial word is discarded; Ntimeout SHALL be at least 2.
REQ-004 SHALL have port clk, input, 1, the clock; all state SHALL change on its rising edge.
REQ-005 SHALL have port reset, input, 1, the reset: asynchronous, active-high.
REQ-006 SHALL have port byte_in_d, input, Nbyte, the byte from the host USB FIFO.
REQ-007 SHALL have port byte_in_v, input, 1, input byte valid.
REQ-008 SHALL have port byte_in_a, output, 1, input byte acknowledge.
REQ-009 SHALL have port word_out_d, output, NPCin, the assembled word for the PC-word parser.
REQ-010 SHALL have port word_out_v, output, 1, output word valid.
REQ-011 SHALL have port word_out_a, input, 1, output word acknowledge.
REQ-012 SHALL have port discard_count, output, 16, the number of partial words dropped by timeout; it SHALL saturate at 0xFFFF.

Function
REQ-013 SHALL treat a transfer as occurring on a rising clk edge where v and a are both 1; this applies to both channels.
REQ-014 SHALL assemble NPCin/Nbyte bytes MSB-first: the first accepted byte becomes word_out_d[NPCin-1:NPCin-Nbyte].
REQ-015 SHALL keep a byte index, range 0..NPCin/Nbyte-1, that increments on each input transfer and wraps to 0 after the last byte.
REQ-016 SHALL load the completed word into a single-entry output register on the edge that accepts the last byte, so word_out_v=1 in the following cycle (latency 1 cycle).
REQ-017 SHALL drive byte_in_a=1 when the index is not the last byte, or when the output register is empty, or when word_out_a=1 in the same cycle.
REQ-018 SHALL hold word_out_d stable while word_out_v=1 and word_out_a=0.
REQ-019 SHALL clear word_out_v on an output transfer unless a new word is loaded on the same edge, in which case word_out_v SHALL remain 1 with the new data.
REQ-020 SHALL keep an idle counter that increments each cycle in which index!=0 and byte_in_v=0, and clears on any input transfer or whenever index==0.
REQ-021 SHALL perform a timeout when the idle counter reaches Ntimeout-1 while byte_in_v=0: on that edge, index SHALL become 0, the partial bytes SHALL be dropped, and discard_count SHALL increment.
REQ-022 SHALL NOT count a cycle as idle when byte_in_v=1 and byte_in_a=0 (stalled on a full output register).
REQ-023 SHALL give an input transfer priority over a timeout when both fall on the same edge: the byte is accepted and no discard occurs.
REQ-024 SHALL never drop or alter a word already held in the output register because of a timeout.

Reset
REQ-025 SHALL, while reset=1, hold: index=0, idle counter=0, word_out_v=0, word_out_d=0, discard_count=0, byte_in_a=0.
REQ-026 SHALL discard any partial word and any held output word when reset is asserted mid-operation.
REQ-027 SHALL resume normal operation on the first rising edge after reset deasserts.

Structure
REQ-028 SHALL place the default NPCin, Nbyte and Ntimeout constants in the shared PC-interface package, alongside the PC word field widths.
REQ-029 SHALL implement the output register and its handshake (REQ-016 to REQ-019) as sub-module pc_word_out_reg.

Verification
REQ-030 SHALL verify assembly: bytes 0xA1, 0xB2, 0xC3, 0xD4 with word_out_a=1 -> word_out_d=0xA1B2C3D4 with word_out_v=1 one cycle after 0xD4 is accepted.
REQ-031 SHALL verify backpressure: with word_out_a=0, send 8 bytes -> first word held, byte_in_a=0 at byte 8; raise word_out_a -> second word delivered, no loss.
REQ-032 SHALL verify timeout: with Ntimeout=16, send 2 bytes then idle 16 cycles -> index=0 and discard_count=1; then send 0x01..0x04 -> 0x01020304.
REQ-033 SHALL verify the tie case: with Ntimeout=16, a byte arrives exactly on the timeout cycle -> it is accepted and discard_count is unchanged.
REQ-034 SHALL verify reset mid-word: after 3 bytes, pulse reset -> word_out_v=0, discard_count=0, and the next 4 bytes form a clean word.
REQ-035 SHALL verify random streaming: random byte_in_v and word_out_a over 10000 bytes -> output words match the scoreboard in order.

Source files
------------

// File: rtl/pc_word_deserializer_pkg.sv
// rtl/pc_word_deserializer_pkg.sv - shared PC-interface constants and PC word field layout
package pc_word_deserializer_pkg;

  // Default deserializer geometry
  localparam int PC_NPCIN    = 32;
  localparam int PC_NBYTE    = 8;
  localparam int PC_NTIMEOUT = 1024;

  // PC word field widths (consumed by the downstream PC-word parser)
  localparam int PC_OPCODE_W = 8;
  localparam int PC_ADDR_W   = 8;
  localparam int PC_DATA_W   = 16;

  typedef struct packed {
    logic [PC_OPCODE_W-1:0] opcode;
    logic [PC_ADDR_W-1:0]   addr;
    logic [PC_DATA_W-1:0]   data;
  } pc_word_t;

endpackage

// File: rtl/pc_word_deserializer_if.sv
// rtl/pc_word_deserializer_if.sv - byte-in / word-out handshake bundle for the deserializer
interface pc_word_deserializer_if
  import pc_word_deserializer_pkg::*;
#(
  parameter int NPCin = PC_NPCIN,
  parameter int Nbyte = PC_NBYTE
) ();

  logic [Nbyte-1:0] byte_in_d;
  logic             byte_in_v;
  logic             byte_in_a;
  logic [NPCin-1:0] word_out_d;
  logic             word_out_v;
  logic             word_out_a;
  logic [15:0]      discard_count;

  // Host/bench side: produces bytes, consumes words
  modport master (
    output byte_in_d, byte_in_v, word_out_a,
    input  byte_in_a, word_out_d, word_out_v, discard_count
  );

  // Deserializer side
  modport slave (
    input  byte_in_d, byte_in_v, word_out_a,
    output byte_in_a, word_out_d, word_out_v, discard_count
  );

endinterface

// File: rtl/pc_word_out_reg.sv
// rtl/pc_word_out_reg.sv - single-entry output word register with valid/ack handshake
module pc_word_out_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ack,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Hold the word until acked; a load on the ack edge keeps valid high with new data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= i_load | (r_valid & ~i_ack);
      if (i_load) r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pc_word_deserializer.sv
// rtl/pc_word_deserializer.sv - MSB-first byte-to-word deserializer with idle timeout
module pc_word_deserializer
  import pc_word_deserializer_pkg::*;
#(
  parameter int NPCin    = PC_NPCIN,
  parameter int Nbyte    = PC_NBYTE,
  parameter int Ntimeout = PC_NTIMEOUT
) (
  input logic clk,
  input logic reset,
  pc_word_deserializer_if.slave bus
);

  localparam int NB    = NPCin / Nbyte;
  localparam int IDXW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int IDLEW = $clog2(Ntimeout);

  logic [IDXW-1:0]  r_idx;
  logic [IDLEW-1:0] r_idle;
  logic [NPCin-1:0] r_acc;
  logic [15:0]      r_discard;

  logic             w_last;
  logic             w_byte_a;
  logic             w_in_xfer;
  logic             w_load;
  logic             w_timeout;
  logic             w_out_v;
  logic [NPCin-1:0] w_out_d;
  logic [NPCin-1:0] w_word;

  assign w_last    = (r_idx == IDXW'(NB - 1));
  // The last byte may only be taken if the output slot is free or freeing this cycle
  assign w_byte_a  = ~reset & (~w_last | ~w_out_v | bus.word_out_a);
  assign w_in_xfer = bus.byte_in_v & w_byte_a;
  assign w_load    = w_in_xfer & w_last;
  // Older bytes shift toward the MSBs so the first byte ends up on top
  assign w_word    = (r_acc << Nbyte) | NPCin'(bus.byte_in_d);
  // A valid byte (even stalled) never triggers a timeout, so a transfer always wins a tie
  assign w_timeout = (r_idx != '0) & ~bus.byte_in_v & (r_idle == IDLEW'(Ntimeout - 1));

  // Byte index and shift accumulator; timeout rewinds the index to drop the partial word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx <= '0;
      r_acc <= '0;
    end else if (w_in_xfer) begin
      r_idx <= w_last ? '0 : r_idx + IDXW'(1);
      r_acc <= w_word;
    end else if (w_timeout) begin
      r_idx <= '0;
    end
  end

  // Idle counter: counts only true gaps mid-word; stalled cycles hold it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idle <= '0;
    end else if (w_in_xfer || (r_idx == '0) || w_timeout) begin
      r_idle <= '0;
    end else if (!bus.byte_in_v) begin
      r_idle <= r_idle + IDLEW'(1);
    end
  end

  // Saturating count of partial words dropped by timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_discard <= '0;
    end else if (w_timeout && (r_discard != 16'hFFFF)) begin
      r_discard <= r_discard + 16'd1;
    end
  end

  pc_word_out_reg #(.W(NPCin)) u_out_reg (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_data  (w_word),
    .i_ack   (bus.word_out_a),
    .o_valid (w_out_v),
    .o_data  (w_out_d)
  );

  assign bus.byte_in_a     = w_byte_a;
  assign bus.word_out_v    = w_out_v;
  assign bus.word_out_d    = w_out_d;
  assign bus.discard_count = r_discard;

endmodule

// File: tb/tb_pc_word_deserializer.sv
// tb/tb_pc_word_deserializer.sv - directed and random self-checking bench for pc_word_deserializer
module tb_pc_word_deserializer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pc_word_deserializer_if #(.NPCin(32), .Nbyte(8)) bus ();

  pc_word_deserializer #(.NPCin(32), .Nbyte(8), .Ntimeout(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Present one byte and wait (bounded) until it is transferred; returns at edge+1
  task automatic send_byte(input logic [7:0] d);
    bit ok = 0;
    bus.byte_in_d = d;
    bus.byte_in_v = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.byte_in_a) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.byte_in_v = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_byte_timeout: byte %h never acknowledged", d);
    end
  endtask

  task automatic test_reset();
    bus.byte_in_v  = 1'b0;
    bus.byte_in_d  = 8'h00;
    bus.word_out_a = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.word_out_v !== 1'b0) begin n_fail++; $display("FAIL reset_word_out_v: got %b want 0", bus.word_out_v); end
    n_checks++; if (bus.word_out_d !== 32'h0) begin n_fail++; $display("FAIL reset_word_out_d: got %h want 0", bus.word_out_d); end
    n_checks++; if (bus.discard_count !== 16'h0) begin n_fail++; $display("FAIL reset_discard: got %h want 0", bus.discard_count); end
    n_checks++; if (bus.byte_in_a !== 1'b0) begin n_fail++; $display("FAIL reset_byte_in_a: got %b want 0", bus.byte_in_a); end
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (bus.byte_in_a !== 1'b1) begin n_fail++; $display("FAIL post_reset_byte_in_a: got %b want 1", bus.byte_in_a); end
  endtask

  task automatic test_assembly();
    bus.word_out_a = 1'b1;
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    n_checks++; if (bus.word_out_v !== 1'b0) begin n_fail++; $display("FAIL asm_early_valid: got %b want 0", bus.word_out_v); end
    send_byte(8'hD4);
    n_checks++; if (bus.word_out_v !== 1'b1) begin n_fail++; $display("FAIL asm_valid: got %b want 1", bus.word_out_v); end
    n_checks++; if (bus.word_out_d !== 32'hA1B2C3D4) begin n_fail++; $display("FAIL asm_data: got %h want A1B2C3D4", bus.word_out_d); end
    @(posedge clk);
    #1;
    n_checks++; if (bus.word_out_v !== 1'b0) begin n_fail++; $display("FAIL asm_valid_clear: got %b want 0", bus.word_out_v); end
  endtask

  task automatic test_backpressure();
    bus.word_out_a = 1'b0;
    for (int i = 0; i < 7; i++) send_byte(8'(8'h11 + i));
    bus.byte_in_d = 8'h18;
    bus.byte_in_v = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.byte_in_a !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ack: got %b want 0", bus.byte_in_a); end
    repeat (20) @(posedge clk);
    #1;
    n_checks++; if (bus.word_out_d !== 32'h11121314) begin n_fail++; $display("FAIL bp_held_data: got %h want 11121314", bus.word_out_d); end
    n_checks++; if (bus.word_out_v !== 1'b1) begin n_fail++; $display("FAIL bp_held_valid: got %b want 1", bus.word_out_v); end
    n_checks++; if (bus.discard_count !== 16'h0) begin n_fail++; $display("FAIL bp_stall_not_idle: got %h want 0", bus.discard_count); end
    bus.word_out_a = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.byte_in_a !== 1'b1) begin n_fail++; $display("FAIL bp_release_ack: got %b want 1", bus.byte_in_a); end
    @(posedge clk);
    #1;
    bus.byte_in_v = 1'b0;
    n_checks++; if (bus.word_out_v !== 1'b1) begin n_fail++; $display("FAIL bp_second_valid: got %b want 1", bus.word_out_v); end
    n_checks++; if (bus.word_out_d !== 32'h15161718) begin n_fail++; $display("FAIL bp_second_data: got %h want 15161718", bus.word_out_d); end
    @(posedge clk);
    #1;
    n_checks++; if (bus.word_out_v !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b want 0", bus.word_out_v); end
  endtask

  task automatic test_timeout();
    bus.word_out_a = 1'b1;
    send_byte(8'hE1);
    send_byte(8'hE2);
    repeat (15) @(posedge clk);
    #1;
    n_checks++; if (bus.discard_count !== 16'h0) begin n_fail++; $display("FAIL to_early: got %h want 0", bus.discard_count); end
    @(posedge clk);
    #1;
    n_checks++; if (bus.discard_count !== 16'h1) begin n_fail++; $display("FAIL to_discard: got %h want 1", bus.discard_count); end
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    n_checks++; if (bus.word_out_v !== 1'b1) begin n_fail++; $display("FAIL to_next_valid: got %b want 1", bus.word_out_v); end
    n_checks++; if (bus.word_out_d !== 32'h01020304) begin n_fail++; $display("FAIL to_next_data: got %h want 01020304", bus.word_out_d); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_tie();
    bus.word_out_a = 1'b1;
    send_byte(8'h21);
    send_byte(8'h22);
    repeat (15) @(posedge clk);
    #1;
    send_byte(8'h23);
    n_checks++; if (bus.discard_count !== 16'h1) begin n_fail++; $display("FAIL tie_discard: got %h want 1", bus.discard_count); end
    send_byte(8'h24);
    n_checks++; if (bus.word_out_v !== 1'b1) begin n_fail++; $display("FAIL tie_valid: got %b want 1", bus.word_out_v); end
    n_checks++; if (bus.word_out_d !== 32'h21222324) begin n_fail++; $display("FAIL tie_data: got %h want 21222324", bus.word_out_d); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    bus.word_out_a = 1'b0;
    send_byte(8'h31); send_byte(8'h32); send_byte(8'h33); send_byte(8'h34);
    send_byte(8'h41); send_byte(8'h42); send_byte(8'h43);
    n_checks++; if (bus.word_out_v !== 1'b1) begin n_fail++; $display("FAIL rm_held_before: got %b want 1", bus.word_out_v); end
    reset = 1'b1;
    #1;
    n_checks++; if (bus.word_out_v !== 1'b0) begin n_fail++; $display("FAIL rm_valid: got %b want 0", bus.word_out_v); end
    n_checks++; if (bus.word_out_d !== 32'h0) begin n_fail++; $display("FAIL rm_data: got %h want 0", bus.word_out_d); end
    n_checks++; if (bus.discard_count !== 16'h0) begin n_fail++; $display("FAIL rm_discard: got %h want 0", bus.discard_count); end
    n_checks++; if (bus.byte_in_a !== 1'b0) begin n_fail++; $display("FAIL rm_byte_in_a: got %b want 0", bus.byte_in_a); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.word_out_a = 1'b1;
    send_byte(8'h5A); send_byte(8'h6B); send_byte(8'h7C); send_byte(8'h8D);
    n_checks++; if (bus.word_out_v !== 1'b1) begin n_fail++; $display("FAIL rm_clean_valid: got %b want 1", bus.word_out_v); end
    n_checks++; if (bus.word_out_d !== 32'h5A6B7C8D) begin n_fail++; $display("FAIL rm_clean_data: got %h want 5A6B7C8D", bus.word_out_d); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [31:0] exp_q[$];
    logic [31:0] acc = '0;
    logic [31:0] w;
    int nb_cnt = 0;
    int sent = 0;
    int got = 0;
    int gap = 0;
    int cyc = 0;
    while ((sent < 10000 || exp_q.size() != 0) && cyc < 80000) begin
      if (sent < 10000) begin
        bus.byte_in_v = (gap >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
        bus.byte_in_d = 8'($urandom);
      end else begin
        bus.byte_in_v = 1'b0;
      end
      bus.word_out_a = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (bus.byte_in_v && bus.byte_in_a) begin
        acc = {acc[23:0], bus.byte_in_d};
        nb_cnt++;
        sent++;
        gap = 0;
        if (nb_cnt == 4) begin
          exp_q.push_back(acc);
          nb_cnt = 0;
        end
      end else if (!bus.byte_in_v) begin
        gap++;
      end
      if (bus.word_out_v && bus.word_out_a) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_unexpected_word: got %h want none", bus.word_out_d);
        end else begin
          w = exp_q.pop_front();
          if (bus.word_out_d !== w) begin
            n_fail++;
            $display("FAIL rnd_word_%0d: got %h want %h", got, bus.word_out_d, w);
          end
        end
        got++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.byte_in_v  = 1'b0;
    bus.word_out_a = 1'b0;
    n_checks++; if (got != 2500) begin n_fail++; $display("FAIL rnd_word_count: got %0d want 2500", got); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_leftover: got %0d want 0", exp_q.size()); end
    n_checks++; if (bus.discard_count !== 16'h0) begin n_fail++; $display("FAIL rnd_discard: got %h want 0", bus.discard_count); end
  endtask

  initial begin
    test_reset();
    test_assembly();
    test_backpressure();
    test_timeout();
    test_tie();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
